// File: rtl/soc_io_uart.sv
// IO-bus responder: LED register, UART TX FIFO + 8N1 serialiser, status register.
// Latency: reads are combinational; a byte pushed into an idle, empty UART starts its start bit one edge later.
// Backpressure: none on the bus; a byte written while the FIFO is full is dropped and flags a sticky overflow.
module soc_io_uart #(
  parameter int CLK_FREQ_HZ = 27000000,
  parameter int BAUD        = 115200,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] IO_mem_addr,
  input  logic [31:0] IO_mem_wdata,
  input  logic        IO_mem_wr,
  output logic [31:0] IO_mem_rdata,
  output logic [5:0]  LEDS,
  output logic        uart_tx
);

  localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD;
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int CW  = PW + 1;
  localparam int BCW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BCW-1:0] BAUD_RELOAD = BCW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]  DEPTH_CNT   = CW'(FIFO_DEPTH);

  generate
    if (CLKS_PER_BIT < 2) begin : g_chk_baud
      $error("soc_io_uart: CLK_FREQ_HZ/BAUD must be at least 2");
    end
    if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_chk_depth
      $error("soc_io_uart: FIFO_DEPTH must be a power of 2 and at least 2");
    end
  endgenerate

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  // One-hot word-address decode; several set bits select several registers.
  logic sel_led, sel_dat, sel_cntl;
  assign sel_led  = IO_mem_addr[2];
  assign sel_dat  = IO_mem_addr[3];
  assign sel_cntl = IO_mem_addr[4];

  logic unused_bits;
  assign unused_bits = ^{IO_mem_addr[31:5], IO_mem_addr[1:0], IO_mem_wdata[31:8]};

  // FIFO state
  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wptr, rptr;
  logic [CW-1:0] count;
  logic          full, empty, push, pop;
  logic          overflow;

  // TX state
  state_t         state_q, state_d;
  logic [BCW-1:0] baud_q, baud_d;
  logic [2:0]     bit_q, bit_d;
  logic [7:0]     shift_q, shift_d;
  logic           tx_q, tx_d;
  logic           busy;

  // Full is taken from the pre-edge count, so a push while full drops even if a pop lands on the same edge.
  assign full  = (count == DEPTH_CNT);
  assign empty = (count == '0);
  assign push  = IO_mem_wr && sel_dat && !full;
  assign busy  = !empty || (state_q != S_IDLE);

  // Combinational read mux: no side effects since the core samples rdata every cycle.
  always_comb begin
    IO_mem_rdata = '0;
    if (sel_led) begin
      IO_mem_rdata = IO_mem_rdata | {26'b0, LEDS};
    end
    if (sel_cntl) begin
      IO_mem_rdata[16 +: CW] = IO_mem_rdata[16 +: CW] | count;
      IO_mem_rdata[10]       = IO_mem_rdata[10] | overflow;
      IO_mem_rdata[9]        = IO_mem_rdata[9] | busy;
      IO_mem_rdata[8]        = IO_mem_rdata[8] | full;
    end
  end

  // LED register write.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      LEDS <= '0;
    end else if (IO_mem_wr && sel_led) begin
      LEDS <= IO_mem_wdata[5:0];
    end
  end

  // Sticky overflow: a dropped byte sets it, firmware clears it; a set on the same edge beats the clear.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      overflow <= 1'b0;
    end else if (IO_mem_wr && sel_dat && full) begin
      overflow <= 1'b1;
    end else if (IO_mem_wr && sel_cntl && IO_mem_wdata[0]) begin
      overflow <= 1'b0;
    end
  end

  // FIFO storage; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (resetn && push) begin
      mem[wptr] <= IO_mem_wdata[7:0];
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at the power-of-2 depth.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
    end
  end

  // TX state register; uart_tx comes straight from a flop so it never glitches.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

  assign uart_tx = tx_q;

  // TX next-state: the registered tx value is computed for the state being entered, so each
  // bit starts on the same edge as its state change; STOP chains straight into the next START.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    pop     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (!empty) begin
          pop     = 1'b1;
          shift_d = mem[rptr];
          baud_d  = BAUD_RELOAD;
          tx_d    = 1'b0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (baud_q == '0) begin
          baud_d  = BAUD_RELOAD;
          bit_d   = '0;
          tx_d    = shift_q[0];
          state_d = S_DATA;
        end else begin
          baud_d = baud_q - 1'b1;
        end
      end
      S_DATA: begin
        if (baud_q == '0) begin
          baud_d = BAUD_RELOAD;
          if (bit_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = S_STOP;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
            tx_d    = shift_q[1];
          end
        end else begin
          baud_d = baud_q - 1'b1;
        end
      end
      S_STOP: begin
        if (baud_q == '0) begin
          if (!empty) begin
            pop     = 1'b1;
            shift_d = mem[rptr];
            baud_d  = BAUD_RELOAD;
            tx_d    = 1'b0;
            state_d = S_START;
          end else begin
            tx_d    = 1'b1;
            state_d = S_IDLE;
          end
        end else begin
          baud_d = baud_q - 1'b1;
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: doc/soc_io_uart.md
Name: soc_io_uart

Overview:
- Memory-mapped IO responder on the core's IO bus (IO_mem_addr/wdata/wr/rdata); the other end of the core's IO store/load path.
- Decodes one-hot word addresses and drives the LED register.
- Buffers UART bytes in a small FIFO and serialises them as 8N1 on uart_tx.
- Exposes a side-effect-free status register so firmware can poll instead of overrunning.

Parameters:
- CLK_FREQ_HZ, 27000000, system clock frequency.
- BAUD, 115200, serial bit rate. CLKS_PER_BIT = CLK_FREQ_HZ/BAUD (integer division); the elaboration check requires at least 2.
- FIFO_DEPTH, 8, TX FIFO entries. Must be a power of 2, at least 2. CW = log2(FIFO_DEPTH)+1.

Ports:
- clk  in  1  system clock
- resetn  in  1  synchronous active-low reset
- IO_mem_addr  in  32  byte address from core. Bit 22 qualification is done by the core; only bits [15:2] are decoded here.
- IO_mem_wdata  in  32  store data
- IO_mem_wr  in  1  one-cycle store strobe, already IO-qualified
- IO_mem_rdata  out  32  read data, combinational from IO_mem_addr
- LEDS  out  6  LED register
- uart_tx  out  1  serial output, idle high

Behaviour:
- Decode: wa = IO_mem_addr[15:2].
  - wa[0] selects LEDS.
  - wa[1] selects UART_DAT.
  - wa[2] selects UART_CNTL.
  - Several set bits select all of them: writes apply to each selected register, and reads OR the selected values together.
- Reads are purely combinational with no side effects, because the core samples rdata speculatively every cycle.
  - LEDS reads {26'b0, LEDS}.
  - UART_DAT reads 0.
  - UART_CNTL reads {zero-pad, count[CW-1:0] at bits [16+CW-1:16], overflow bit10, busy bit9, full bit8}.
  - busy = FIFO non-empty OR FSM not IDLE.
  - Unselected reads return 0.
- Writes are sampled on the clk edge where IO_mem_wr=1.
  - LEDS: LEDS <= wdata[5:0].
  - UART_DAT: push wdata[7:0] if not full. If full, the byte is dropped and overflow is set sticky.
  - UART_CNTL: wdata[0]=1 clears overflow. If a set and a clear occur in the same cycle, the set wins.
- FIFO:
  - Circular buffer with wrapping read/write pointers and a count of 0..FIFO_DEPTH.
  - full = (count==FIFO_DEPTH).
  - Full is evaluated on the pre-edge state: a push while full is dropped even if a pop happens in the same cycle.
  - Push and pop in the same cycle while not full: count unchanged.
- TX FSM states: IDLE, START, DATA, STOP. A baud counter counts CLKS_PER_BIT-1 down to 0; bit index runs 0..7.
  - IDLE: tx=1. If FIFO non-empty, pop into the shift register and go to START. uart_tx goes low on the same edge.
  - START: tx=0 for CLKS_PER_BIT cycles, then DATA.
  - DATA: tx=shift[0], LSB first. Shift after each CLKS_PER_BIT cycles; after 8 bits go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. At the end, if FIFO non-empty, pop and go to START with no idle gap; otherwise go to IDLE.
  - uart_tx is registered (glitch-free).
- Latency and throughput:
  - A push at edge N into an empty FIFO with the FSM in IDLE is popped at edge N+1, and uart_tx is low from N+1.
  - Back-to-back bytes take exactly 10*CLKS_PER_BIT cycles each.
- Reset (resetn=0 at an edge), including mid-frame:
  - LEDS=0, uart_tx=1, FSM=IDLE, FIFO emptied (pointers and count 0), overflow=0, counters 0.
  - A write in the reset cycle is ignored.
- Arithmetic: pointers are log2(FIFO_DEPTH) bits and wrap naturally. The baud counter is wide enough for CLKS_PER_BIT-1.

Test Plan:
- Common setup: CLK_FREQ_HZ=16, BAUD=4 (CLKS_PER_BIT=4), FIFO_DEPTH=4.
- Reset then read: hold resetn=0 2 cycles -> LEDS=0, uart_tx=1, rdata at addr 0x400010 = 0.
- LEDS: write 0x3F to addr 0x400004 -> LEDS=6'h3F next cycle; read at 0x400004 returns 0x3F; read at 0x400010 shows busy=0.
- Single byte: write 0x55 to 0x400008 at edge N -> uart_tx low for cycles N+1..N+4, then bits 1,0,1,0,1,0,1,0 at 4 cycles each, high at N+37..N+40; busy=0 from N+41.
- Back-to-back: write 0xA5 then 0x0F on consecutive cycles -> second start bit begins exactly 40 cycles after the first, with no idle high gap beyond the stop bit.
- Overflow: 6 consecutive writes 0x01..0x06 to UART_DAT while idle -> first pops immediately; 0x02..0x05 fill the FIFO; 0x06 is dropped. CNTL reads full=1, overflow=1, count=4. Write 1 to 0x400010 -> overflow=0. Serial output is 0x01..0x05 only.
- Reset mid-frame: assert resetn=0 during DATA bit 3 of 0x00 -> uart_tx=1 next edge, count=0; no further frames after release.
